// File: rtl/alu_driver_if.sv
// Shared ALU encodings plus the command/response port bundle of alu_driver.
// The master modport is the stimulus side; the slave modport is the driver.

package types;

   // Encoding 0 of each type is its reset literal.
   typedef enum logic [1:0] {
      ADD      = 2'd0,
      SUBTRACT = 2'd1,
      MULTIPLY = 2'd2,
      NOP      = 2'd3
   } sel_t;

   typedef enum logic {
      NO_CARRY   = 1'b0,
      WITH_CARRY = 1'b1
   } mode_t;

endpackage

interface alu_driver_if;

   logic         Cmd_Valid;
   logic         Cmd_Ready;
   logic [3:0]   Cmd_Op1;
   logic [3:0]   Cmd_Op2;
   types::sel_t  Cmd_Sel;
   logic         Cmd_C_In;
   types::mode_t Cmd_Mode;

   logic         Rsp_Valid;
   logic         Rsp_Ready;
   logic [7:0]   Rsp_Result;
   logic         Rsp_Equal;

   modport master (
      output Cmd_Valid, Cmd_Op1, Cmd_Op2, Cmd_Sel, Cmd_C_In, Cmd_Mode, Rsp_Ready,
      input  Cmd_Ready, Rsp_Valid, Rsp_Result, Rsp_Equal
   );

   modport slave (
      input  Cmd_Valid, Cmd_Op1, Cmd_Op2, Cmd_Sel, Cmd_C_In, Cmd_Mode, Rsp_Ready,
      output Cmd_Ready, Rsp_Valid, Rsp_Result, Rsp_Equal
   );

endinterface

// File: rtl/alu_driver.sv
// alu_driver: queues ALU commands in a DEPTH-entry FIFO, issues them one at a
// time to a registered 4-bit ALU, and returns Result/Equal in command order.
// Optional feature: define ALU_DRIVER_CHECK_EN to compile a result checker that
// raises the sticky Mismatch flag; otherwise Mismatch is tied low.

module alu_driver #(
   parameter int unsigned DEPTH = 4
) (
   input  logic         Clock,
   input  logic         Reset_N,
   alu_driver_if.slave  bus,
   output logic [3:0]   Op1,
   output logic [3:0]   Op2,
   output types::sel_t  Sel,
   output logic         C_In,
   output types::mode_t Mode,
   input  logic [7:0]   Result,
   input  logic         Equal,
   output logic         Busy,
   output logic         Mismatch
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef struct packed {
      logic [3:0]   op1;
      logic [3:0]   op2;
      types::sel_t  sel;
      logic         c_in;
      types::mode_t mode;
   } cmd_t;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StCapture,
      StResp
   } state_e;

   // ---------------------------------------------------------------------------
   // Command FIFO
   // ---------------------------------------------------------------------------
   cmd_t              fifo_q [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]   count_q;
   logic              full, empty, push, pop;
   cmd_t              cmd_in, head;

   assign full   = (count_q == CntW'(DEPTH));
   assign empty  = (count_q == '0);
   assign push   = bus.Cmd_Valid && !full;
   assign head   = fifo_q[rd_ptr_q];
   assign cmd_in = '{op1:  bus.Cmd_Op1,
                     op2:  bus.Cmd_Op2,
                     sel:  bus.Cmd_Sel,
                     c_in: bus.Cmd_C_In,
                     mode: bus.Cmd_Mode};

   assign bus.Cmd_Ready = !full;

   // Storage needs no reset: occupancy is tracked solely by count_q.
   always_ff @(posedge Clock) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= cmd_in;
      end
   end

   // Pointers and occupancy; a simultaneous push and pop leaves the count alone.
   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Issue/capture FSM
   // ---------------------------------------------------------------------------
   state_e state_q, state_d;
   logic   rsp_valid_q, rsp_valid_d;
   logic   capture;

   // State register.
   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         state_q     <= StIdle;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // Next state, FIFO pop and response-valid control.
   always_comb begin
      state_d     = state_q;
      rsp_valid_d = rsp_valid_q;
      pop         = 1'b0;
      capture     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = StIssue;
            end
         end
         // ALU samples its held inputs at the edge closing this state.
         StIssue: begin
            state_d = StCapture;
         end
         // ALU output is registered and valid here; latch it at the closing edge.
         StCapture: begin
            capture     = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = StResp;
         end
         StResp: begin
            if (bus.Rsp_Ready) begin
               rsp_valid_d = 1'b0;
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = StIssue;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // ALU input registers and response capture
   // ---------------------------------------------------------------------------
   logic [3:0]   op1_q, op2_q;
   types::sel_t  sel_q;
   logic         c_in_q;
   types::mode_t mode_q;
   logic [7:0]   rsp_result_q;
   logic         rsp_equal_q;

   // ALU inputs change only on pop and otherwise hold the last issued command.
   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         op1_q  <= 4'd0;
         op2_q  <= 4'd0;
         sel_q  <= types::ADD;
         c_in_q <= 1'b0;
         mode_q <= types::NO_CARRY;
      end else if (pop) begin
         op1_q  <= head.op1;
         op2_q  <= head.op2;
         sel_q  <= head.sel;
         c_in_q <= head.c_in;
         mode_q <= head.mode;
      end
   end

   // Response data is written only in CAPTURE, so it holds while stalled.
   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         rsp_result_q <= 8'd0;
         rsp_equal_q  <= 1'b0;
      end else if (capture) begin
         rsp_result_q <= Result;
         rsp_equal_q  <= Equal;
      end
   end

   assign Op1  = op1_q;
   assign Op2  = op2_q;
   assign Sel  = sel_q;
   assign C_In = c_in_q;
   assign Mode = mode_q;

   assign bus.Rsp_Valid  = rsp_valid_q;
   assign bus.Rsp_Result = rsp_result_q;
   assign bus.Rsp_Equal  = rsp_equal_q;

   assign Busy = (state_q != StIdle) || !empty;

   // ---------------------------------------------------------------------------
   // Optional result checker
   // ---------------------------------------------------------------------------
`ifdef ALU_DRIVER_CHECK_EN
   cmd_t       chk_q;
   logic [7:0] exp_result;
   logic       exp_equal;
   logic       mismatch_q;

   // Private copy of the issued command for the checker.
   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         chk_q <= '0;
      end else if (pop) begin
         chk_q <= head;
      end
   end

   // Reference ALU: 8-bit modular arithmetic on zero-extended operands.
   always_comb begin
      logic [7:0] a8, b8, cy8;
      a8         = {4'd0, chk_q.op1};
      b8         = {4'd0, chk_q.op2};
      cy8        = (chk_q.mode == types::WITH_CARRY) ? {7'd0, chk_q.c_in} : 8'd0;
      exp_result = 8'd0;
      exp_equal  = (chk_q.op1 == chk_q.op2);
      case (chk_q.sel)
         types::ADD:      exp_result = a8 + b8 + cy8;
         types::SUBTRACT: exp_result = a8 - b8 - cy8;
         types::MULTIPLY: exp_result = a8 * b8;
         default:         exp_result = 8'd0;
      endcase
   end

   // Sticky until reset.
   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         mismatch_q <= 1'b0;
      end else if (capture && ((Result != exp_result) || (Equal != exp_equal))) begin
         mismatch_q <= 1'b1;
      end
   end

   assign Mismatch = mismatch_q;
`else
   assign Mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a registered ALU stub that can be biased
// to return a wrong Result.

module tb_alu_driver;

   logic         Clock = 1'b0;
   logic         Reset_N;
   logic [3:0]   Op1, Op2;
   types::sel_t  Sel;
   logic         C_In;
   types::mode_t Mode;
   logic [7:0]   Result = 8'd0;
   logic         Equal  = 1'b0;
   logic         Busy, Mismatch;
   logic [7:0]   alu_bias = 8'd0;

   int checks   = 0;
   int failures = 0;

`ifdef ALU_DRIVER_CHECK_EN
   localparam logic ExpMis = 1'b1;
`else
   localparam logic ExpMis = 1'b0;
`endif

   alu_driver_if bus ();

   alu_driver #(.DEPTH(4)) dut (
      .Clock    (Clock),
      .Reset_N  (Reset_N),
      .bus      (bus),
      .Op1      (Op1),
      .Op2      (Op2),
      .Sel      (Sel),
      .C_In     (C_In),
      .Mode     (Mode),
      .Result   (Result),
      .Equal    (Equal),
      .Busy     (Busy),
      .Mismatch (Mismatch)
   );

   always #5 Clock = ~Clock;

   function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                         input types::sel_t s, input logic c,
                                         input types::mode_t m);
      logic [7:0] cy;
      cy = (m == types::WITH_CARRY) ? {7'd0, c} : 8'd0;
      case (s)
         types::ADD:      return {4'd0, a} + {4'd0, b} + cy;
         types::SUBTRACT: return {4'd0, a} - {4'd0, b} - cy;
         types::MULTIPLY: return {4'd0, a} * {4'd0, b};
         default:         return 8'd0;
      endcase
   endfunction

   // Registered ALU stub with one cycle of latency.
   always_ff @(posedge Clock) begin
      Result <= alu_fn(Op1, Op2, Sel, C_In, Mode) + alu_bias;
      Equal  <= (Op1 == Op2);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic push(input logic [3:0] a, input logic [3:0] b, input types::sel_t s,
                       input logic c, input types::mode_t m);
      bus.Cmd_Valid = 1'b1;
      bus.Cmd_Op1   = a;
      bus.Cmd_Op2   = b;
      bus.Cmd_Sel   = s;
      bus.Cmd_C_In  = c;
      bus.Cmd_Mode  = m;
      tick();
      bus.Cmd_Valid = 1'b0;
   endtask

   // Ticks until Rsp_Valid is seen (bounded); n is the number of edges waited.
   task automatic wait_valid(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.Rsp_Valid && n < 20);
      check("rsp_arrive", 32'(bus.Rsp_Valid), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int accepts;
      int seen;
      logic ready_before;

      bus.Cmd_Valid = 1'b0;
      bus.Cmd_Op1   = 4'd0;
      bus.Cmd_Op2   = 4'd0;
      bus.Cmd_Sel   = types::ADD;
      bus.Cmd_C_In  = 1'b0;
      bus.Cmd_Mode  = types::NO_CARRY;
      bus.Rsp_Ready = 1'b0;
      Reset_N       = 1'b1;
      #2 Reset_N    = 1'b0;
      tick();
      tick();

      // Reset values
      check("rst_cmd_ready", 32'(bus.Cmd_Ready), 32'd1);
      check("rst_rsp_valid", 32'(bus.Rsp_Valid), 32'd0);
      check("rst_rsp_result", 32'(bus.Rsp_Result), 32'd0);
      check("rst_rsp_equal", 32'(bus.Rsp_Equal), 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_mismatch", 32'(Mismatch), 32'd0);
      check("rst_ops", 32'({Op1, Op2, Sel, C_In, Mode}), 32'd0);
      #3 Reset_N = 1'b1;
      tick();

      // ADD with carry: 9+8+1 = 0x12, valid 3 edges after pop
      push(4'd9, 4'd8, types::ADD, 1'b1, types::WITH_CARRY);
      check("t1_busy_after_push", 32'(Busy), 32'd1);
      tick();
      check("t1_pop_op1", 32'(Op1), 32'd9);
      check("t1_pop_op2", 32'(Op2), 32'd8);
      check("t1_pop_cin_mode", 32'({C_In, Mode}), 32'd3);
      tick();
      check("t1_valid_pop_plus2", 32'(bus.Rsp_Valid), 32'd0);
      tick();
      check("t1_valid_pop_plus3", 32'(bus.Rsp_Valid), 32'd1);
      check("t1_result", 32'(bus.Rsp_Result), 32'h12);
      check("t1_equal", 32'(bus.Rsp_Equal), 32'd0);
      bus.Rsp_Ready = 1'b1;
      tick();
      check("t1_valid_cleared", 32'(bus.Rsp_Valid), 32'd0);
      check("t1_idle_busy", 32'(Busy), 32'd0);
      check("t1_op1_retained", 32'(Op1), 32'd9);

      // SUBTRACT (carry ignored without WITH_CARRY) then MULTIPLY, in order
      push(4'd3, 4'd5, types::SUBTRACT, 1'b1, types::NO_CARRY);
      push(4'd15, 4'd15, types::MULTIPLY, 1'b0, types::NO_CARRY);
      wait_valid(n);
      check("t2_sub_result", 32'(bus.Rsp_Result), 32'hFE);
      check("t2_sub_equal", 32'(bus.Rsp_Equal), 32'd0);
      wait_valid(n);
      check("t2_mul_result", 32'(bus.Rsp_Result), 32'hE1);
      check("t2_mul_equal", 32'(bus.Rsp_Equal), 32'd1);
      check("t2_mul_spacing", 32'(n), 32'd3);
      tick();

      // ADD 7+7: equal operands
      push(4'd7, 4'd7, types::ADD, 1'b0, types::NO_CARRY);
      wait_valid(n);
      check("t3_result", 32'(bus.Rsp_Result), 32'h0E);
      check("t3_equal", 32'(bus.Rsp_Equal), 32'd1);
      tick();

      // Capacity: stalled response, continuous push -> DEPTH+1 accepts
      bus.Rsp_Ready = 1'b0;
      accepts = 0;
      for (int i = 0; i < 12; i++) begin
         ready_before  = bus.Cmd_Ready;
         bus.Cmd_Valid = 1'b1;
         bus.Cmd_Op1   = 4'(accepts);
         bus.Cmd_Op2   = 4'd1;
         bus.Cmd_Sel   = types::ADD;
         bus.Cmd_C_In  = 1'b0;
         bus.Cmd_Mode  = types::NO_CARRY;
         tick();
         if (ready_before) accepts++;
      end
      bus.Cmd_Valid = 1'b0;
      check("t4_accepts", 32'(accepts), 32'd5);
      check("t4_cmd_ready_low", 32'(bus.Cmd_Ready), 32'd0);
      check("t4_stalled_valid", 32'(bus.Rsp_Valid), 32'd1);
      check("t4_stalled_result", 32'(bus.Rsp_Result), 32'h01);
      tick();
      check("t4_stalled_result_hold", 32'(bus.Rsp_Result), 32'h01);
      bus.Rsp_Ready = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         wait_valid(n);
         check("t4_order_result", 32'(bus.Rsp_Result), 32'(k));
         check("t4_spacing", 32'(n), 32'd3);
      end
      check("t4_cmd_ready_back", 32'(bus.Cmd_Ready), 32'd1);
      tick();
      check("t4_drained_busy", 32'(Busy), 32'd0);

      // Reset during CAPTURE with two commands queued
      bus.Rsp_Ready = 1'b0;
      push(4'd4, 4'd4, types::ADD, 1'b0, types::NO_CARRY);
      push(4'd5, 4'd1, types::ADD, 1'b0, types::NO_CARRY);
      push(4'd6, 4'd1, types::ADD, 1'b0, types::NO_CARRY);
      check("t5_pre_op1", 32'(Op1), 32'd4);
      check("t5_pre_busy", 32'(Busy), 32'd1);
      Reset_N = 1'b0;
      #1;
      check("t5_rst_op1", 32'(Op1), 32'd0);
      check("t5_rst_busy", 32'(Busy), 32'd0);
      check("t5_rst_cmd_ready", 32'(bus.Cmd_Ready), 32'd1);
      check("t5_rst_rsp_result", 32'(bus.Rsp_Result), 32'd0);
      check("t5_rst_rsp_valid", 32'(bus.Rsp_Valid), 32'd0);
      #2 Reset_N = 1'b1;
      bus.Rsp_Ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.Rsp_Valid) seen++;
      end
      check("t5_no_responses", 32'(seen), 32'd0);
      push(4'd2, 4'd3, types::ADD, 1'b0, types::NO_CARRY);
      wait_valid(n);
      check("t5_post_latency", 32'(n), 32'd3);
      check("t5_post_result", 32'(bus.Rsp_Result), 32'h05);
      tick();

      // Checker: second op gets a corrupted ALU result
      push(4'd1, 4'd2, types::ADD, 1'b0, types::NO_CARRY);
      wait_valid(n);
      check("t6_op1_result", 32'(bus.Rsp_Result), 32'h03);
      check("t6_op1_mismatch", 32'(Mismatch), 32'd0);
      tick();
      alu_bias = 8'd1;
      push(4'd9, 4'd4, types::SUBTRACT, 1'b0, types::NO_CARRY);
      wait_valid(n);
      check("t6_op2_passthrough", 32'(bus.Rsp_Result), 32'h06);
      check("t6_op2_mismatch", 32'(Mismatch), 32'(ExpMis));
      tick();
      alu_bias = 8'd0;
      push(4'd1, 4'd1, types::ADD, 1'b0, types::NO_CARRY);
      wait_valid(n);
      check("t6_op3_result", 32'(bus.Rsp_Result), 32'h02);
      check("t6_mismatch_sticky", 32'(Mismatch), 32'(ExpMis));
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
